reg_file_param: RTL and testbench

Parametrised next-generation integer register file for the RISC-V datapath.
- Configurable data width, register count and number of read ports.
- Register 0 hardwired to zero.
- Write-to-read bypass.
- Sequenced hardware clear after reset, with a busy indication and a dropped-write flag.
- Sits between decode (read addresses) and writeback (write port).

---
 rtl/reg_file_pkg.sv | 15 +
 rtl/reg_read_port.sv | 30 +++
 rtl/reg_file_param.sv | 80 ++++++++
 tb/tb_reg_file_param.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the parametrised integer register file.
package reg_file_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam int ZERO_REG = 0;

    function automatic int addr_width(input int nregs);
        return $clog2(nregs);
    endfunction

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port: clear/zero-register overrides, same-cycle
// write forwarding, otherwise the addressed storage word.
module reg_read_port
    import reg_file_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  rf_state_e        state,
    input  logic [AW-1:0]    ra,
    input  logic [XLEN-1:0]  regs [NREGS],
    input  logic             we,
    input  logic [AW-1:0]    rw,
    input  logic [XLEN-1:0]  din,
    output logic [XLEN-1:0]  dout
);

    always_comb begin
        dout = '0;
        if (state == READY && ra != AW'(ZERO_REG)) begin
            if (we && rw == ra) begin
                dout = din;
            end else begin
                dout = regs[ra];
            end
        end
    end

endmodule

// File: rtl/reg_file_param.sv
// Integer register file with hardwired zero register, write bypass and a
// sequenced post-reset clear of registers 1..NREGS-1.
//
// state | meaning
// CLEAR | zeroing one register per cycle; reads return 0, writes dropped
// READY | normal operation; writes commit, reads forward same-cycle writes
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter  int XLEN  = 64,
    parameter  int NREGS = 32,
    parameter  int NREAD = 2,
    localparam int AW    = addr_width(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREAD*AW-1:0]    ra,
    output logic [NREAD*XLEN-1:0]  dout,
    input  logic                   we,
    input  logic [AW-1:0]          rw,
    input  logic [XLEN-1:0]        din,
    output logic                   busy,
    output logic                   wr_dropped
);

    rf_state_e        state;
    logic [AW-1:0]    clr_idx;
    logic [XLEN-1:0]  regs [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            clr_idx    <= AW'(1);
            wr_dropped <= we;
        end else begin
            case (state)
                CLEAR: begin
                    clr_idx    <= clr_idx + AW'(1);
                    wr_dropped <= we;
                    if (clr_idx == AW'(NREGS - 1)) begin
                        state <= READY;
                    end
                end
                default: begin
                    wr_dropped <= 1'b0;
                end
            endcase
        end
    end

    // Storage is deliberately left untouched by reset; the clear walk defines it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                regs[clr_idx] <= '0;
            end else if (we && rw != AW'(ZERO_REG)) begin
                regs[rw] <= din;
            end
        end
    end

    assign busy = (state == CLEAR);

    for (genvar k = 0; k < NREAD; k++) begin : g_read
        reg_read_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .AW    (AW)
        ) u_port (
            .state (state),
            .ra    (ra[k*AW +: AW]),
            .regs  (regs),
            .we    (we),
            .rw    (rw),
            .din   (din),
            .dout  (dout[k*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed scenarios plus random traffic against a behavioural register-file model.
module tb_reg_file_param;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREAD*AW-1:0]   ra;
    logic [NREAD*XLEN-1:0] dout;
    logic                  we;
    logic [AW-1:0]         rw;
    logic [XLEN-1:0]       din;
    logic                  busy;
    logic                  wr_dropped;

    always #5 clk = ~clk;

    reg_file_param #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
        .clk        (clk),
        .reset      (reset),
        .ra         (ra),
        .dout       (dout),
        .we         (we),
        .rw         (rw),
        .din        (din),
        .busy       (busy),
        .wr_dropped (wr_dropped)
    );

    int total = 0;
    int bad   = 0;

    // Model: register contents, whether a clear is in progress and how many
    // clear cycles remain, and the expected dropped-write flag.
    logic [XLEN-1:0] mem [NREGS];
    bit              clearing;
    int              remaining;
    bit              exp_drop;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] pred(input logic [AW-1:0] a);
        if (clearing) return '0;
        if (a == 0) return '0;
        if (we && rw == a) return din;
        return mem[a];
    endfunction

    task automatic check_outputs();
        for (int k = 0; k < NREAD; k++) begin
            chk($sformatf("dout%0d", k), dout[k*XLEN +: XLEN], pred(ra[k*AW +: AW]));
        end
        chk("busy", XLEN'(busy), XLEN'(clearing));
        chk("wr_dropped", XLEN'(wr_dropped), XLEN'(exp_drop));
    endtask

    task automatic update_model();
        if (reset) begin
            clearing  = 1'b1;
            remaining = NREGS - 1;
            exp_drop  = we;
        end else if (clearing) begin
            exp_drop = we;
            remaining--;
            if (remaining == 0) begin
                clearing = 1'b0;
                for (int i = 0; i < NREGS; i++) mem[i] = '0;
            end
        end else begin
            exp_drop = 1'b0;
            if (we && rw != 0) mem[rw] = din;
        end
    endtask

    task automatic step(input bit do_check = 1'b1);
        @(negedge clk);
        if (do_check) check_outputs();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic count_busy(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk(tag, XLEN'(n), XLEN'(NREGS - 1));
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        ra = {a1, a0};
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) mem[i] = 'x;
        clearing  = 1'b1;
        remaining = NREGS - 1;
        exp_drop  = 1'b0;
        reset = 1'b1; we = 1'b0; rw = '0; din = '0; ra = '0;

        // Clear timing
        step(1'b0);
        step();
        reset = 1'b0;
        count_busy("busy_cycles_initial");
        for (int r = 0; r < NREGS; r++) begin
            set_ra(AW'(r), AW'(r));
            #1;
            chk("cleared_port0", dout[0 +: XLEN], '0);
            chk("cleared_port1", dout[XLEN +: XLEN], '0);
            step();
        end

        // Write with same-cycle bypass, then both ports read it back
        we = 1'b1; rw = 5; din = 64'hDEAD_BEEF_0123_4567; set_ra(5, 0);
        #1 chk("bypass_r5", dout[0 +: XLEN], 64'hDEAD_BEEF_0123_4567);
        step();
        we = 1'b0; set_ra(5, 5);
        #1 chk("read_r5_p0", dout[0 +: XLEN], 64'hDEAD_BEEF_0123_4567);
        chk("read_r5_p1", dout[XLEN +: XLEN], 64'hDEAD_BEEF_0123_4567);
        step();

        // Zero register ignores writes
        we = 1'b1; rw = 0; din = '1; set_ra(0, 0);
        #1 chk("zero_during_write", dout[0 +: XLEN], '0);
        step();
        we = 1'b0;
        #1 chk("zero_after_write", dout[0 +: XLEN], '0);
        chk("zero_no_drop", XLEN'(wr_dropped), '0);
        step();

        // Register 11 holds a value before the next reset
        we = 1'b1; rw = 11; din = 64'h1234;
        step();
        we = 1'b0;
        step();

        // Reset, dropped write during clear, then reset mid-clear
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin
                we = 1'b1; rw = 7; din = 64'h55;
            end else begin
                we = 1'b0;
            end
            step();
            if (c == 4) chk("dropped_pulse", XLEN'(wr_dropped), XLEN'(1));
        end
        we = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        count_busy("busy_cycles_restart");
        set_ra(11, 7);
        #1 chk("r11_cleared", dout[0 +: XLEN], '0);
        chk("r7_cleared", dout[XLEN +: XLEN], '0);
        step();

        // Independent ports with bypass on one
        we = 1'b1; rw = 3; din = 64'hA;
        step();
        rw = 9; din = 64'hB;
        step();
        rw = 9; din = 64'hC; set_ra(3, 9);
        #1 chk("indep_p0", dout[0 +: XLEN], 64'hA);
        chk("indep_p1_bypass", dout[XLEN +: XLEN], 64'hC);
        step();
        we = 1'b0;
        #1 chk("indep_p1_next", dout[XLEN +: XLEN], 64'hC);
        step();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            we    = reset ? 1'b0 : 1'($urandom_range(0, 1));
            rw    = AW'($urandom);
            din   = {$urandom, $urandom};
            for (int k = 0; k < NREAD; k++) begin
                ra[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? rw : AW'($urandom);
            end
            step();
        end
        reset = 1'b0; we = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
